// File: rtl/residual_gen_luma16x16_if.sv
// residual_gen_luma16x16_if: neighbour capture, row handshake and residual outputs of the 16x16 luma residual generator
interface residual_gen_luma16x16_if;
  logic start, top_avail, left_avail, row_valid, row_ready, busy, sad_enable;
  logic [7:0] top [16];
  logic [7:0] left [16];
  logic [7:0] orig_row [16];
  logic [7:0] vres [256];
  logic [7:0] hres [256];
  logic [7:0] dcres [256];
  logic [2:0] mode_avail;
  modport master (
    output start, top, left, top_avail, left_avail, row_valid, orig_row,
    input  row_ready, busy, vres, hres, dcres, mode_avail, sad_enable
  );
  modport slave (
    input  start, top, left, top_avail, left_avail, row_valid, orig_row,
    output row_ready, busy, vres, hres, dcres, mode_avail, sad_enable
  );
endinterface

// File: rtl/residual_gen_luma16x16.sv
// residual_gen_luma16x16: intra 16x16 luma V/H/DC residuals, one original row per handshake, then a SAD enable pulse
module residual_gen_luma16x16 (
  input logic clk,
  input logic reset,
  residual_gen_luma16x16_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DCCALC, ROWS, DONE} state_t;
  state_t state, nxt;
  logic [3:0] row_cnt;
  logic [7:0] top_q [16];
  logic [7:0] left_q [16];
  logic ta_q, la_q;
  logic [7:0] dc_q, dc_nxt;
  logic [2:0] mode_q;
  logic [7:0] vres_q [256];
  logic [7:0] hres_q [256];
  logic [7:0] dcres_q [256];
  logic [11:0] sum_t, sum_l, rnd_t, rnd_l;
  logic [12:0] rnd_tl;
  logic acc;
  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d > 9'sd127 ? 8'h7f : d < -9'sd128 ? 8'h80 : d[7:0];
  endfunction
  assign acc = state == ROWS && bus.row_valid;
  assign bus.row_ready = state == ROWS;
  assign bus.busy = state != IDLE;
  assign bus.sad_enable = state == DONE;
  assign bus.mode_avail = mode_q;
  assign bus.vres = vres_q;
  assign bus.hres = hres_q;
  assign bus.dcres = dcres_q;
  always_comb begin
    nxt = state == IDLE ? (bus.start ? DCCALC : IDLE) :
          state == DCCALC ? ROWS :
          state == ROWS ? (acc && row_cnt == 4'd15 ? DONE : ROWS) : IDLE;
  end
  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int i = 0; i < 16; i++) begin
      sum_t = sum_t + {4'd0, top_q[i]};
      sum_l = sum_l + {4'd0, left_q[i]};
    end
    rnd_t = sum_t + 12'd8;
    rnd_l = sum_l + 12'd8;
    rnd_tl = {1'b0, sum_t} + {1'b0, sum_l} + 13'd16;
    dc_nxt = ta_q && la_q ? rnd_tl[12:5] : ta_q ? rnd_t[11:4] : la_q ? rnd_l[11:4] : 8'd128;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row_cnt <= '0;
      ta_q <= 1'b0;
      la_q <= 1'b0;
      dc_q <= '0;
      mode_q <= 3'b100;
      for (int i = 0; i < 16; i++) begin
        top_q[i] <= '0;
        left_q[i] <= '0;
      end
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        top_q <= bus.top;
        left_q <= bus.left;
        ta_q <= bus.top_avail;
        la_q <= bus.left_avail;
        mode_q <= {1'b1, bus.left_avail, bus.top_avail};
      end
      if (state == DCCALC) begin
        dc_q <= dc_nxt;
        row_cnt <= '0;
      end else if (acc) row_cnt <= row_cnt + 4'd1;
    end
  end
  // Rows overwrite in place, so untouched rows keep the previous block's residuals.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        vres_q[i] <= '0;
        hres_q[i] <= '0;
        dcres_q[i] <= '0;
      end
    end else if (acc) begin
      for (int x = 0; x < 16; x++) begin
        vres_q[{row_cnt, 4'(x)}] <= sat8(bus.orig_row[x], ta_q ? top_q[x] : 8'd128);
        hres_q[{row_cnt, 4'(x)}] <= sat8(bus.orig_row[x], la_q ? left_q[row_cnt] : 8'd128);
        dcres_q[{row_cnt, 4'(x)}] <= sat8(bus.orig_row[x], dc_q);
      end
    end
  end
endmodule

// File: tb/tb_residual_gen_luma16x16.sv
// tb_residual_gen_luma16x16: randomized and directed blocks scored against an integer reference model at each SAD enable
module tb_residual_gen_luma16x16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  residual_gen_luma16x16_if bus ();
  residual_gen_luma16x16 dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] mode;
    logic [2047:0] v;
    logic [2047:0] h;
    logic [2047:0] d;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [7:0] cur_top [16];
  logic [7:0] cur_left [16];
  logic [7:0] cur_orig [256];
  bit cur_ta, cur_la;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat(input int d);
    return d < -128 ? 8'h80 : d > 127 ? 8'h7f : 8'(d);
  endfunction

  function automatic exp_t model();
    exp_t e;
    int st = 0, sl = 0, dc, o, ph;
    for (int i = 0; i < 16; i++) begin
      st += int'(cur_top[i]);
      sl += int'(cur_left[i]);
    end
    dc = cur_ta && cur_la ? (st + sl + 16) / 32 : cur_ta ? (st + 8) / 16 : cur_la ? (sl + 8) / 16 : 128;
    e.mode = {1'b1, cur_la, cur_ta};
    for (int r = 0; r < 16; r++) begin
      ph = cur_la ? int'(cur_left[r]) : 128;
      for (int x = 0; x < 16; x++) begin
        o = int'(cur_orig[r*16+x]);
        e.v[(r*16+x)*8 +: 8] = sat(o - (cur_ta ? int'(cur_top[x]) : 128));
        e.h[(r*16+x)*8 +: 8] = sat(o - ph);
        e.d[(r*16+x)*8 +: 8] = sat(o - dc);
      end
    end
    return e;
  endfunction

  // Monitor: scores each SAD enable, its timing, row_ready outside ROWS and array hold during stalls.
  int acc_cnt = 0;
  bit prev_acc = 0, prev_stall = 0;
  logic [7:0] snap_v [256];
  logic [7:0] snap_h [256];
  logic [7:0] snap_d [256];
  always @(negedge clk) begin
    exp_t e;
    int bv, bh, bd;
    if (!reset) begin
      acc_cnt = 0;
      prev_acc = 0;
      prev_stall = 0;
    end else begin
      if (!bus.busy || bus.sad_enable) check("row_ready_outside_rows", 32'(bus.row_ready), 0);
      if (bus.sad_enable) begin
        check("sad_after_16th_accept", 32'(prev_acc && acc_cnt == 16), 1);
        if (q.size() == 0) check("sad_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          check("mode_avail", 32'(bus.mode_avail), 32'(e.mode));
          bv = 0; bh = 0; bd = 0;
          for (int i = 0; i < 256; i++) begin
            if (bus.vres[i] !== e.v[i*8 +: 8]) bv++;
            if (bus.hres[i] !== e.h[i*8 +: 8]) bh++;
            if (bus.dcres[i] !== e.d[i*8 +: 8]) bd++;
          end
          check("vres_bad_entries", bv, 0);
          check("hres_bad_entries", bh, 0);
          check("dcres_bad_entries", bd, 0);
        end
        acc_cnt = 0;
      end
      if (prev_stall) begin
        bv = 0;
        for (int i = 0; i < 256; i++)
          if (bus.vres[i] !== snap_v[i] || bus.hres[i] !== snap_h[i] || bus.dcres[i] !== snap_d[i]) bv++;
        check("stall_hold_changed_entries", bv, 0);
      end
      snap_v = bus.vres;
      snap_h = bus.hres;
      snap_d = bus.dcres;
      prev_stall = bus.row_ready && !bus.row_valid;
      prev_acc = bus.row_ready && bus.row_valid;
      if (prev_acc) acc_cnt++;
    end
  end

  task automatic check_reset_state(input string tag);
    int nz = 0;
    for (int i = 0; i < 256; i++) if (bus.vres[i] != 0 || bus.hres[i] != 0 || bus.dcres[i] != 0) nz++;
    check({tag, "_nonzero_entries"}, nz, 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_row_ready"}, 32'(bus.row_ready), 0);
    check({tag, "_sad_enable"}, 32'(bus.sad_enable), 0);
    check({tag, "_mode_avail"}, 32'(bus.mode_avail), 3'b100);
  endtask

  task automatic scramble_nbrs();
    for (int i = 0; i < 16; i++) begin
      bus.top[i] = 8'($urandom);
      bus.left[i] = 8'($urandom);
    end
    bus.top_avail = 1'($urandom);
    bus.left_avail = 1'($urandom);
  endtask

  // stall_pct < 0 gives the fixed valid pattern 1,0,0,1,0,0,...; abort_at >= 0 resets before that row.
  task automatic run_block(input int stall_pct, input bit poke, input int abort_at);
    if (abort_at < 0) q.push_back(model());
    bus.top = cur_top;
    bus.left = cur_left;
    bus.top_avail = cur_ta;
    bus.left_avail = cur_la;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble_nbrs();
    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) begin
      if (abort_at == r) begin
        reset = 1'b0;
        #1;
        check_reset_state("abort");
        @(posedge clk); #1;
        bus.row_valid = 1'b0;
        reset = 1'b1;
        return;
      end
      for (int s = 0; (stall_pct < 0) ? (r > 0 && s < 2) : ($urandom_range(99) < stall_pct && s < 20); s++) begin
        bus.row_valid = 1'b0;
        bus.start = poke;
        scramble_nbrs();
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.row_valid = 1'b1;
      for (int x = 0; x < 16; x++) bus.orig_row[x] = cur_orig[r*16+x];
      bus.start = poke && r == 5;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.row_valid = 1'b0;
    bus.start = poke;
    scramble_nbrs();
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      check("sad_timeout", 32'(q.size()), 0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic fill(input int t, input int l, input int o);
    for (int i = 0; i < 16; i++) begin
      cur_top[i] = 8'(t);
      cur_left[i] = 8'(l);
    end
    for (int i = 0; i < 256; i++) cur_orig[i] = 8'(o);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      cur_top[i] = 8'($urandom);
      cur_left[i] = 8'($urandom);
    end
    for (int i = 0; i < 256; i++) cur_orig[i] = 8'($urandom);
    cur_ta = 1'($urandom);
    cur_la = 1'($urandom);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.row_valid = 1'b0;
    for (int i = 0; i < 16; i++) bus.orig_row[i] = '0;
    scramble_nbrs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    fill(100, 60, 90); cur_ta = 1; cur_la = 1;
    run_block(0, 0, -1);
    check("t1_vres", 32'(bus.vres[0]), 8'hF6);
    check("t1_hres", 32'(bus.hres[255]), 8'd30);
    check("t1_dcres", 32'(bus.dcres[100]), 8'd10);
    fill(0, 0, 0); cur_ta = 0; cur_la = 0;
    run_block(0, 0, -1);
    check("t2_mode", 32'(bus.mode_avail), 3'b100);
    check("t2_vres_sat", 32'(bus.vres[17]), 8'h80);
    check("t2_dcres_sat", 32'(bus.dcres[255]), 8'h80);
    fill(0, 0, 255); cur_ta = 1; cur_la = 0;
    for (int i = 0; i < 16; i++) begin
      cur_top[i] = 8'(i * 16);
      cur_left[i] = 8'($urandom);
    end
    run_block(0, 0, -1);
    check("t3_vres_x8", 32'(bus.vres[8]), 8'd127);
    check("t3_vres_x15", 32'(bus.vres[16*3+15]), 8'd15);
    check("t3_hres", 32'(bus.hres[40]), 8'd127);
    check("t3_dcres", 32'(bus.dcres[200]), 8'd127);
    fill(100, 60, 90); cur_ta = 1; cur_la = 1;
    run_block(-1, 0, -1);
    fill_random();
    run_block(0, 0, 8);
    check_reset_state("post_abort");
    fill_random();
    run_block(10, 0, -1);
    fill_random();
    run_block(30, 1, -1);
    for (int b = 0; b < 20; b++) begin
      fill_random();
      run_block($urandom_range(40), 1'($urandom), -1);
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
